// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Program counter and fetch sequencer that sits behind the branch-target
// lookup table. It steps the instruction-memory address sequentially, takes
// absolute jumps or PC-relative branches, and runs an IDLE/RUN/DONE machine
// with saturating cycle and taken-branch counters.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   start      in   pulse: begin/restart the program at address 0
//   stall      in   hold the PC this cycle (highest priority in RUN)
//   halt_req   in   halt instruction decoded at the current PC
//   branch_en  in   branch/jump taken this cycle
//   rel_en     in   1 = pc + target (two's complement), 0 = target
//   target     in   D-bit jump target or offset
//   prog_ctr   out  current fetch address
//   running    out  high while in RUN
//   done       out  high while in DONE
//   cycle_cnt  out  cycles spent in RUN (saturating)
//   branch_cnt out  taken branches retired (saturating)
// All outputs are registered; a decision made in a cycle shows after the
// following rising edge.
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int D  = 10,
    parameter int CW = 16,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          branch_en,
    input  logic          rel_en,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycle_cnt,
    output logic [BW-1:0] branch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [D-1:0]    pc_next_s;
    logic [CW-1:0]   cyc_next_s;
    logic [BW-1:0]   br_next_s;
    logic [CW-1:0]   cyc_inc_s;
    logic [BW-1:0]   br_inc_s;

    // Saturating increments of both counters.
    always_comb begin
        cyc_inc_s = (cycle_cnt == {CW{1'b1}}) ? cycle_cnt
                                              : cycle_cnt + {{(CW-1){1'b0}}, 1'b1};
        br_inc_s  = (branch_cnt == {BW{1'b1}}) ? branch_cnt
                                               : branch_cnt + {{(BW-1){1'b0}}, 1'b1};
    end

    // Next-state and next-value logic for the run/halt sequencer.
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = prog_ctr;
        cyc_next_s   = cycle_cnt;
        br_next_s    = branch_cnt;
        case (state_r)
            IDLE, DONE: begin
                // DONE holds everything for readout; start restarts as from IDLE.
                if (start) begin
                    next_state_s = RUN;
                    pc_next_s    = {D{1'b0}};
                    cyc_next_s   = {CW{1'b0}};
                    br_next_s    = {BW{1'b0}};
                end else begin
                    next_state_s = state_r;
                end
            end
            RUN: begin
                // The halt cycle and stalled cycles are counted too.
                cyc_next_s = cyc_inc_s;
                if (stall) begin
                    pc_next_s = prog_ctr;
                end else if (halt_req) begin
                    next_state_s = DONE;
                    pc_next_s    = prog_ctr;
                end else if (branch_en) begin
                    br_next_s = br_inc_s;
                    if (rel_en) begin
                        // Two's-complement offset; carry out is dropped (mod 2^D).
                        pc_next_s = prog_ctr + target;
                    end else begin
                        pc_next_s = target;
                    end
                end else begin
                    pc_next_s = prog_ctr + {{(D-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                next_state_s = IDLE;
                pc_next_s    = {D{1'b0}};
                cyc_next_s   = {CW{1'b0}};
                br_next_s    = {BW{1'b0}};
            end
        endcase
    end

    // State and output registers; running/done are decoded from the next state
    // so they stay registered and aligned with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            prog_ctr   <= {D{1'b0}};
            cycle_cnt  <= {CW{1'b0}};
            branch_cnt <= {BW{1'b0}};
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            prog_ctr   <= pc_next_s;
            cycle_cnt  <= cyc_next_s;
            branch_cnt <= br_next_s;
            running    <= (next_state_s == RUN);
            done       <= (next_state_s == DONE);
        end
    end

endmodule
